declyr_seq: RTL and testbench
=============================

Name: declyr_seq

Overview:
- Time-multiplexed decoder-side layer for the 3x3-image VAE.
- Accepts a 2-element latent vector (z1, z2) and expands it into N_OUT outputs using one shared 2-input MAC: out[j] = z1*w1[j] + z2*w2[j] + b[j].
- Sits downstream of the encoder's 2-input MAC layers and is the inverse-direction stage: 2 in, many out.
- Coefficients are held in an internal register file loaded through a simple config write port.

Parameters:
- N_OUT, 9, number of output neurons (one per 3x3 pixel).
- DW, 16, data width; signed Q8.8 fixed point.
- FRAC, 8, fractional bits.
- AW, 6, config address width; must satisfy 2^AW >= 3*N_OUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  AW  coefficient address: 0..N_OUT-1 = w1[j]; N_OUT..2N_OUT-1 = w2[j]; 2N_OUT..3N_OUT-1 = b[j].
- cfg_data  in  DW  coefficient value, Q8.8.
- in_valid  in  1  latent vector valid.
- in_ready  out  1  block can accept a vector.
- z1  in  DW  latent element 1, Q8.8.
- z2  in  DW  latent element 2, Q8.8.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  DW  output neuron value, Q8.8, saturated.
- out_idx  out  4  index j of the current output (0..N_OUT-1).
- out_last  out  1  high with out_valid when out_idx == N_OUT-1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
Reset (async, rst_n=0):
- State goes to IDLE.
- in_ready=1; out_valid=0; out_data=0; out_idx=0; out_last=0; busy=0.
- Captured z1/z2 cleared.
- All 3*N_OUT coefficient registers cleared to 0.
- Reset asserted mid-vector abandons the vector; no further outputs are produced for it.

States:
- IDLE:
  - in_ready=1.
  - On in_valid, latch z1 and z2, set idx=0, go to CALC.
- CALC (1 cycle):
  - Compute out[idx] and register it into out_data.
  - Drive out_idx=idx and out_last=(idx==N_OUT-1).
  - Go to OUT.
- OUT:
  - out_valid=1; out_data, out_idx and out_last are held stable until the handshake.
  - On out_ready with idx==N_OUT-1: go to IDLE.
  - On out_ready otherwise: idx+1, go to CALC.
  - out_valid drops for the CALC cycle between outputs.

Handshake and timing:
- Latency: first out_valid is 2 cycles after the in_valid&&in_ready cycle.
- With out_ready held high, one output every 2 cycles.
- A full vector takes 2*N_OUT cycles.
- in_ready=0 outside IDLE; in_valid is ignored there.
- The vector handshake in IDLE and the final output handshake cannot coincide, so there is no simultaneous accept.

Arithmetic:
- Products are signed DWxDW -> 2DW.
- Bias is sign-extended and shifted left by FRAC.
- Sum of the two products and the shifted bias is formed at 2DW+2 bits.
- Result is arithmetic right shift by FRAC (truncation toward -inf).
- Saturate to [0x8000, 0x7FFF].

Config port:
- A write lands on the next clk edge, only when state==IDLE.
- Writes while busy=1 are dropped, so the active vector sees coherent coefficients.
- Addresses >= 3*N_OUT are ignored.
- A write and an in_valid accept in the same IDLE cycle: the write lands and the new vector uses the updated value.

Test Plan:
- Load w1[0]=w2[0]=0x0040, b[0]=0x0000; apply z1=z2=0x0400 -> out_idx=0, out_data=0x0200, first out_valid 2 cycles after accept.
- Load w1[j]=w2[j]=0x0080, b[j]=0x0100 for all j; apply z1=z2=0x0100 with out_ready=1 -> 9 outputs of 0x0200, out_idx 0..8, out_last only on idx 8, done in 18 cycles, then in_ready=1.
- Saturation: w1[0]=w2[0]=0x7FFF, z1=z2=0x7FFF, b[0]=0x7FFF -> 0x7FFF; same with z1=z2=0x8000 -> 0x8000.
- Backpressure: hold out_ready=0 for 5 cycles at idx 3 -> out_valid stays 1 and out_data/out_idx remain stable; release -> idx 4 follows after 1 CALC cycle.
- Config while busy: write b[5]=0x0300 during a vector -> vector outputs use the old b[5]; the next vector shows the new value. Write to addr 27 -> no coefficient changes.
- Reset mid-vector at idx 4 -> out_valid=0, in_ready=1 immediately (async); all coefficients read back as 0 via a subsequent vector output of 0x0000.

Source files
------------

// File: rtl/declyr_seq.sv
// Decoder-side expansion layer: one shared 2-input MAC turns a latent pair (z1, z2)
// into N_OUT saturated Q8.8 outputs, one per CALC/OUT cycle pair.
module declyr_seq #(
  parameter int N_OUT = 9,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int AW    = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic signed [DW-1:0] cfg_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] z1,
  input  logic signed [DW-1:0] z2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic [3:0]           out_idx,
  output logic                 out_last,
  output logic                 busy
);

  localparam int WS = 2*DW + 2;
  localparam logic [3:0] LAST = 4'(N_OUT-1);
  localparam logic signed [DW-1:0] OMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] OMIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t               state;
  logic [3:0]           idx;
  logic signed [DW-1:0] z1_p0, z2_p0;
  logic signed [DW-1:0] w1 [N_OUT];
  logic signed [DW-1:0] w2 [N_OUT];
  logic signed [DW-1:0] bq [N_OUT];
  logic signed [DW-1:0] w1_sel, w2_sel, b_sel, mac_res;

  function automatic logic signed [DW-1:0] sat_q(input logic signed [WS-1:0] v);
    if (v > WS'(OMAX))      return OMAX;
    else if (v < WS'(OMIN)) return OMIN;
    else                    return v[DW-1:0];
  endfunction

  // Full-precision sum, then floor shift back to Q8.8 before clamping.
  function automatic logic signed [DW-1:0] mac_q(input logic signed [DW-1:0] a1,
                                                 input logic signed [DW-1:0] c1,
                                                 input logic signed [DW-1:0] a2,
                                                 input logic signed [DW-1:0] c2,
                                                 input logic signed [DW-1:0] bias);
    logic signed [2*DW-1:0] m1, m2;
    logic signed [WS-1:0]   acc;
    m1  = a1 * c1;
    m2  = a2 * c2;
    acc = WS'(m1) + WS'(m2) + (WS'(bias) <<< FRAC);
    return sat_q(acc >>> FRAC);
  endfunction

  always_comb begin
    w1_sel = '0;
    w2_sel = '0;
    b_sel  = '0;
    for (int j = 0; j < N_OUT; j++) begin
      if (idx == 4'(j)) begin
        w1_sel = w1[j];
        w2_sel = w2[j];
        b_sel  = bq[j];
      end
    end
    mac_res = mac_q(z1_p0, w1_sel, z2_p0, w2_sel, b_sel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      z1_p0     <= '0;
      z2_p0     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      for (int j = 0; j < N_OUT; j++) begin
        w1[j] <= '0;
        w2[j] <= '0;
        bq[j] <= '0;
      end
    end else begin
      // Coefficients only change between vectors so an active vector sees one set.
      if (state == IDLE && cfg_we) begin
        for (int j = 0; j < N_OUT; j++) begin
          if (cfg_addr == AW'(j))           w1[j] <= cfg_data;
          if (cfg_addr == AW'(N_OUT + j))   w2[j] <= cfg_data;
          if (cfg_addr == AW'(2*N_OUT + j)) bq[j] <= cfg_data;
        end
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            z1_p0    <= z1;
            z2_p0    <= z2;
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          out_data  <= mac_res;
          out_idx   <= idx;
          out_last  <= (idx == LAST);
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == LAST) begin
              in_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              idx   <= idx + 4'd1;
              state <= CALC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_declyr_seq.sv
// Directed bench for declyr_seq: reset, latency, full vector timing, saturation,
// backpressure, config gating and asynchronous mid-vector reset.
module tb_declyr_seq;
  localparam int N  = 9;
  localparam int DW = 16;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n, cfg_we, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data, z1, z2, out_data;
  logic [3:0]    out_idx;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] got_d [N];
  logic [3:0]    got_i [N];
  logic          got_l [N];
  int            got_n;
  bit            got_done;

  declyr_seq #(.N_OUT(N), .DW(DW), .FRAC(8), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready), .z1(z1), .z2(z2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic cfg_write(input int a, input logic [DW-1:0] d);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic load_all(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    for (int j = 0; j < N; j++) begin
      cfg_write(j, a);
      cfg_write(N + j, b);
      cfg_write(2*N + j, c);
    end
  endtask

  // wmode: 0 none, 1 write on the accept cycle, 2 write while busy
  task automatic run_vec(input logic [DW-1:0] a, input logic [DW-1:0] b, input int wmode,
                         input int waddr, input logic [DW-1:0] wdata);
    got_n = 0; got_done = 0; out_ready = 1'b1;
    z1 = a; z2 = b; in_valid = 1'b1;
    if (wmode == 1) begin cfg_we = 1'b1; cfg_addr = AW'(waddr); cfg_data = wdata; end
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0;
    for (int k = 1; k <= 40 && !got_done; k++) begin
      if (out_valid) begin
        if (got_n < N) begin
          got_d[got_n] = out_data; got_i[got_n] = out_idx; got_l[got_n] = out_last;
        end
        got_n++;
        if (out_last) got_done = 1;
      end
      if (wmode == 2 && k == 3) begin cfg_we = 1'b1; cfg_addr = AW'(waddr); cfg_data = wdata; end
      else cfg_we = 1'b0;
      @(negedge clk);
    end
    cfg_we = 1'b0; out_ready = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 40 && !in_ready; t++) @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL drain_timeout in_ready=%b required 1", in_ready); end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    checks++; if (in_ready  !== 1'b1)  begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data  !== 16'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0000", out_data); end
    checks++; if (out_idx   !== 4'h0)  begin failures++; $display("FAIL rst_out_idx got=%h exp=0", out_idx); end
    checks++; if (out_last  !== 1'b0)  begin failures++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
    checks++; if (busy      !== 1'b0)  begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    cfg_write(0, 16'h0040);
    cfg_write(N, 16'h0040);
    cfg_write(2*N, 16'h0000);
    z1 = 16'h0400; z2 = 16'h0400; in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_lat1_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b1)      begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1)    begin failures++; $display("FAIL single_lat2_valid got=%b exp=1", out_valid); end
    checks++; if (out_idx !== 4'd0)      begin failures++; $display("FAIL single_idx got=%0d exp=0", out_idx); end
    checks++; if (out_data !== 16'h0200) begin failures++; $display("FAIL single_data got=%h exp=0200", out_data); end
    checks++; if (out_last !== 1'b0)     begin failures++; $display("FAIL single_last got=%b exp=0", out_last); end
    drain();
  endtask

  task automatic test_full_vector();
    load_all(16'h0080, 16'h0080, 16'h0100);
    out_ready = 1'b1;
    z1 = 16'h0100; z2 = 16'h0100; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      if (k % 2 == 0 && k <= 18) begin
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL full_valid k=%0d got=%b exp=1", k, out_valid); end
        checks++; if (out_idx !== 4'((k-2)/2)) begin failures++; $display("FAIL full_idx k=%0d got=%0d exp=%0d", k, out_idx, (k-2)/2); end
        checks++; if (out_data !== 16'h0200) begin failures++; $display("FAIL full_data k=%0d got=%h exp=0200", k, out_data); end
        checks++; if (out_last !== (k == 18)) begin failures++; $display("FAIL full_last k=%0d got=%b exp=%b", k, out_last, k == 18); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_gap k=%0d got=%b exp=0", k, out_valid); end
      end
      checks++; if (in_ready !== (k == 19)) begin failures++; $display("FAIL full_in_ready k=%0d got=%b exp=%b", k, in_ready, k == 19); end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    cfg_write(0, 16'h7FFF);
    cfg_write(N, 16'h7FFF);
    cfg_write(2*N, 16'h7FFF);
    run_vec(16'h7FFF, 16'h7FFF, 0, 0, 16'h0);
    checks++; if (!got_done) begin failures++; $display("FAIL sat_pos_timeout outputs=%0d exp=9", got_n); end
    checks++; if (got_d[0] !== 16'h7FFF) begin failures++; $display("FAIL sat_pos got=%h exp=7FFF", got_d[0]); end
    run_vec(16'h8000, 16'h8000, 0, 0, 16'h0);
    checks++; if (got_d[0] !== 16'h8000) begin failures++; $display("FAIL sat_neg got=%h exp=8000", got_d[0]); end
    cfg_write(0, 16'h0080);
    cfg_write(N, 16'h0080);
    cfg_write(2*N, 16'h0100);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    z1 = 16'h0100; z2 = 16'h0100; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 0; j <= 3; j++) begin
      for (int t = 0; t < 6 && !out_valid; t++) @(negedge clk);
      checks++; if (out_idx !== 4'(j)) begin failures++; $display("FAIL bp_idx got=%0d exp=%0d valid=%b", out_idx, j, out_valid); end
      if (j < 3) begin
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
      end
    end
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1)    begin failures++; $display("FAIL bp_hold_valid t=%0d got=%b exp=1", t, out_valid); end
      checks++; if (out_data !== 16'h0200) begin failures++; $display("FAIL bp_hold_data t=%0d got=%h exp=0200", t, out_data); end
      checks++; if (out_idx !== 4'd3)      begin failures++; $display("FAIL bp_hold_idx t=%0d got=%0d exp=3", t, out_idx); end
    end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_calc_gap got=%b exp=0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_idx !== 4'd4) begin
      failures++; $display("FAIL bp_next valid=%b idx=%0d exp valid=1 idx=4", out_valid, out_idx);
    end
    drain();
  endtask

  task automatic test_cfg_busy();
    run_vec(16'h0100, 16'h0100, 2, 2*N + 5, 16'h0300);
    checks++; if (!got_done) begin failures++; $display("FAIL cfg_busy_timeout outputs=%0d exp=9", got_n); end
    checks++; if (got_d[5] !== 16'h0200) begin failures++; $display("FAIL cfg_busy_old_b5 got=%h exp=0200", got_d[5]); end
    checks++; if (got_i[8] !== 4'd8 || got_l[8] !== 1'b1) begin
      failures++; $display("FAIL cfg_busy_last idx=%0d last=%b exp idx=8 last=1", got_i[8], got_l[8]);
    end
    cfg_write(2*N + 5, 16'h0300);
    cfg_write(27, 16'h7777);
    run_vec(16'h0100, 16'h0100, 0, 0, 16'h0);
    checks++; if (got_d[5] !== 16'h0400) begin failures++; $display("FAIL cfg_new_b5 got=%h exp=0400", got_d[5]); end
    checks++; if (got_d[0] !== 16'h0200) begin failures++; $display("FAIL cfg_addr27_d0 got=%h exp=0200", got_d[0]); end
    checks++; if (got_d[8] !== 16'h0200) begin failures++; $display("FAIL cfg_addr27_d8 got=%h exp=0200", got_d[8]); end
    run_vec(16'h0100, 16'h0100, 1, 2*N + 5, 16'h0100);
    checks++; if (got_d[5] !== 16'h0200) begin failures++; $display("FAIL cfg_accept_write got=%h exp=0200", got_d[5]); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    z1 = 16'h0100; z2 = 16'h0100; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int t = 0; t < 30 && !(out_valid && out_idx == 4'd4); t++) @(negedge clk);
    checks++; if (!(out_valid && out_idx == 4'd4)) begin failures++; $display("FAIL rmid_reach_idx4 idx=%0d valid=%b", out_idx, out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_abandoned t=%0d got=%b exp=0", t, out_valid); end
    end
    out_ready = 1'b0;
    run_vec(16'h0100, 16'h0100, 0, 0, 16'h0);
    checks++; if (!got_done) begin failures++; $display("FAIL rmid_vec_timeout outputs=%0d exp=9", got_n); end
    checks++; if (got_d[0] !== 16'h0000) begin failures++; $display("FAIL rmid_zero_d0 got=%h exp=0000", got_d[0]); end
    checks++; if (got_d[5] !== 16'h0000) begin failures++; $display("FAIL rmid_zero_d5 got=%h exp=0000", got_d[5]); end
    checks++; if (got_d[8] !== 16'h0000) begin failures++; $display("FAIL rmid_zero_d8 got=%h exp=0000", got_d[8]); end
  endtask

  initial begin
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; out_ready = 1'b0; z1 = '0; z2 = '0;
    test_reset();
    test_single();
    test_full_vector();
    test_saturation();
    test_backpressure();
    test_cfg_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
